pl_mmio_timer: RTL and testbench
================================

PL_MMIO_TIMER -- requirements
Module: pl_mmio_timer

Interface
REQ-001 Parameter IO_BASE, 24'h00FFFF, the block SHALL respond when addr[31:8] equals IO_BASE (window 0x00FFFF00-0x00FFFFFF).
REQ-002 Parameter GPIO_W, 8, the width of the GPIO in and out ports.
REQ-003 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-004 clrn  in  1  asynchronous, active-low reset.
REQ-005 we  in  1  write enable from the CPU data port (MEM-stage mwmem).
REQ-006 addr  in  32  byte address from the CPU (malu); addr[1:0] SHALL be ignored.
REQ-007 datain  in  32  write data from the CPU (mb).
REQ-008 dataout  out  32  read data to the CPU, combinational from addr.
REQ-009 hit  out  1  high when addr is inside the window; the CPU-side mux uses it to select dataout over data memory.
REQ-010 gpio_in  in  GPIO_W  asynchronous external inputs.
REQ-011 gpio_out  out  GPIO_W  registered general-purpose outputs.
REQ-012 irq  out  1  interrupt request, equal to match_flag AND irq_en.

Function
REQ-013 The register map SHALL decode addr[7:2] as follows:
- 0x00 GPIO_OUT: RW, bits[GPIO_W-1:0].
- 0x04 GPIO_IN: RO, synchronised value.
- 0x08 CTRL: RW; bit0 en, bit1 autoclr, bits[15:8] pre.
- 0x0C COUNT: RW, 32 bits.
- 0x10 CMP: RW, 32 bits.
- 0x14 STATUS: bit0 match_flag (W1C), bit1 irq_en (RW).
REQ-014 Unmapped offsets SHALL read 0 and SHALL ignore writes; unimplemented bits SHALL read 0.
REQ-015 Reads SHALL have zero latency: dataout is valid in the same cycle as addr; dataout SHALL be 0 when hit is 0.
REQ-016 Writes SHALL take effect on the rising edge on which we=1 and hit=1, and SHALL be visible on reads from the next cycle onward.
REQ-017 gpio_in SHALL pass through a 2-flop synchroniser; GPIO_IN SHALL reflect a pin change exactly 2 clock edges later.
REQ-018 Prescaler: an 8-bit pcnt SHALL run while en=1; tick SHALL assert when pcnt==pre, and pcnt SHALL return to 0 on tick.
- pre=0 SHALL give a tick every cycle.
- Clearing en SHALL hold COUNT and reset pcnt to 0.
REQ-019 On a tick with COUNT!=CMP, COUNT SHALL increment modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-020 On a tick with COUNT==CMP:
- match_flag SHALL set.
- COUNT SHALL load 0 when autoclr=1; otherwise it SHALL increment per REQ-019.
REQ-021 A CPU write to COUNT in the same cycle as a tick SHALL win; the tick's increment is discarded.
REQ-022 A write of 1 to STATUS bit0 SHALL clear match_flag; a write of 0 SHALL leave it unchanged.
REQ-023 If a match set and a W1C clear occur in the same cycle, the set SHALL win and match_flag stays 1.
REQ-024 A write to CTRL that changes pre SHALL reset pcnt to 0 on the same edge.
REQ-025 irq SHALL be combinational from the registered match_flag and irq_en, so it asserts 1 cycle after the matching tick edge.

Reset
REQ-026 Asserting clrn=0 SHALL immediately clear GPIO_OUT, both synchroniser stages, CTRL, COUNT, pcnt, match_flag and irq_en to 0, and SHALL set CMP to 0xFFFFFFFF.
REQ-027 Reset asserted mid-count SHALL abandon any in-progress tick; after release, counting SHALL stay stopped until software sets en.

Structure
REQ-028 The register offsets, CTRL and STATUS bit positions, and the CMP reset value SHALL live in a shared package, pl_mmio_pkg, for reuse by CPU-side glue and benches.
REQ-029 The prescaler plus counter SHALL be one sub-module, pl_timer_core (inputs en, pre, load, load_val, cmp, autoclr; outputs count, match); the synchroniser and decode stay in the top level.

Verification
REQ-030 Reset value check: pulse clrn low mid-run, then read every offset. Required: all registers read 0 except CMP=0xFFFFFFFF; irq=0; gpio_out=0.
REQ-031 GPIO round trip: write 0x000000A5 to 0xFFFF00, and drive gpio_in=0x3C. Required: gpio_out=0xA5 one edge after the write; GPIO_IN reads 0x3C from the 2nd edge after the pin change, and a read at the 1st edge still returns the old value.
REQ-032 Prescale and wrap: COUNT=0xFFFFFFFE, CMP=0x10, CTRL=0x0301 (pre=3, en=1). Required: COUNT goes to 0xFFFFFFFF after 4 edges and to 0 after 8 edges; match_flag stays 0.
REQ-033 Match with autoclr: CMP=5, STATUS irq_en=1, CTRL=0x0003. Required: the tick at COUNT=5 sets match_flag, COUNT reads 0 next cycle, and irq=1; then a write of 1 to STATUS clears irq the following cycle.
REQ-034 Simultaneous events:
- Write COUNT=0x100 on a tick edge. Required: COUNT reads 0x100, not the incremented value.
- W1C in the same cycle as a match. Required: match_flag remains 1.
REQ-035 Out-of-window and unmapped access:
- Accesses at addr 0x00FFFE14 SHALL give hit=0, dataout=0 and no state change.
- A write to offset 0x3C SHALL be ignored, and offset 0x3C SHALL read 0.

Source files
------------

// File: rtl/pl_mmio_pkg.sv
// Shared definitions for the memory-mapped GPIO/timer block.
// Holds the register word indices (addr[7:2]), the CTRL and STATUS bit
// positions and the CMP reset value, so CPU-side glue and benches can
// decode the map the same way the block does.
package pl_mmio_pkg;

  // Word index of each register inside the 256-byte window (addr[7:2]).
  typedef enum logic [5:0] {
    IDX_GPIO_OUT = 6'h00,  // byte offset 0x00
    IDX_GPIO_IN  = 6'h01,  // byte offset 0x04
    IDX_CTRL     = 6'h02,  // byte offset 0x08
    IDX_COUNT    = 6'h03,  // byte offset 0x0C
    IDX_CMP      = 6'h04,  // byte offset 0x10
    IDX_STATUS   = 6'h05   // byte offset 0x14
  } reg_idx_e;

  // CTRL layout
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_AUTOCLR_BIT = 1;
  localparam int CTRL_PRE_LSB     = 8;
  localparam int CTRL_PRE_MSB     = 15;

  // STATUS layout
  localparam int STATUS_MATCH_BIT = 0;  // write 1 to clear
  localparam int STATUS_IRQEN_BIT = 1;

  // CMP comes out of reset at the far end of the count range.
  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/pl_mmio_timer_if.sv
// CPU data-port view of the MMIO block.
//   we      - write strobe (MEM-stage store)
//   addr    - byte address; bits [1:0] are ignored by the block
//   datain  - store data
//   dataout - combinational read data, 0 outside the window
//   hit     - address falls inside the block's window
interface pl_mmio_timer_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        hit;

  modport master (output we, addr, datain, input dataout, hit);
  modport slave  (input we, addr, datain, output dataout, hit);
endinterface

// File: rtl/pl_timer_core.sv
// Prescaler plus 32-bit up-counter with compare.
//   en        - run the prescaler; when low COUNT holds and pcnt returns to 0
//   pre       - prescale value; a tick fires when pcnt == pre (pre=0: every cycle)
//   restart   - force pcnt back to 0 (software changed pre)
//   load      - load COUNT from load_val; takes priority over a tick
//   cmp       - compare value
//   autoclr   - on a matching tick, COUNT reloads 0 instead of incrementing
//   count     - current COUNT
//   match     - one-cycle pulse: tick while COUNT == cmp
module pl_timer_core (
  input  logic        clk,
  input  logic        clrn,
  input  logic        en,
  input  logic [7:0]  pre,
  input  logic        restart,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic [31:0] cmp,
  input  logic        autoclr,
  output logic [31:0] count,
  output logic        match
);

  logic [7:0]  pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d;
  logic        tick;

  assign tick  = en && (pcnt_q == pre);
  assign match = tick && (count_q == cmp);
  assign count = count_q;

  always_comb begin
    pcnt_d = (!en || restart || tick) ? 8'd0 : pcnt_q + 8'd1;

    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick) begin
      // Increment wraps naturally at 2^32.
      count_d = (match && autoclr) ? 32'd0 : count_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pcnt_q  <= '0;
      count_q <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pl_mmio_timer.sv
// Memory-mapped GPIO and timer peripheral.
//   clk, clrn  - clock and asynchronous active-low reset
//   bus        - CPU data port (we/addr/datain in, dataout/hit out)
//   gpio_in    - asynchronous pins, read through a 2-flop synchroniser
//   gpio_out   - registered outputs written via GPIO_OUT
//   irq        - match_flag AND irq_en
// Register decode and the synchroniser live here; counting is in pl_timer_core.
module pl_mmio_timer
  import pl_mmio_pkg::*;
#(
  parameter logic [23:0] IO_BASE = 24'h00FFFF,
  parameter int          GPIO_W  = 8
) (
  input  logic              clk,
  input  logic              clrn,
  pl_mmio_timer_if.slave    bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic              en_q, en_d;
  logic              autoclr_q, autoclr_d;
  logic [7:0]        pre_q, pre_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_flag_q, match_flag_d;
  logic              irq_en_q, irq_en_d;

  logic [5:0]  idx;
  logic        wr;
  logic        load;
  logic        restart;
  logic [31:0] count;
  logic        match;
  logic        unused_ok;

  assign bus.hit   = (bus.addr[31:8] == IO_BASE);
  assign idx       = bus.addr[7:2];
  assign wr        = bus.we && bus.hit;
  assign load      = wr && (idx == IDX_COUNT);
  assign restart   = wr && (idx == IDX_CTRL) &&
                     (bus.datain[CTRL_PRE_MSB:CTRL_PRE_LSB] != pre_q);
  assign unused_ok = &{1'b0, bus.addr[1:0]};

  assign gpio_out = gpio_out_q;
  assign irq      = match_flag_q && irq_en_q;

  pl_timer_core u_core (
    .clk      (clk),
    .clrn     (clrn),
    .en       (en_q),
    .pre      (pre_q),
    .restart  (restart),
    .load     (load),
    .load_val (bus.datain),
    .cmp      (cmp_q),
    .autoclr  (autoclr_q),
    .count    (count),
    .match    (match)
  );

  // Register writes.
  // NOTE: every variable assigned here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gpio_out_d   = gpio_out_q;
    en_d         = en_q;
    autoclr_d    = autoclr_q;
    pre_d        = pre_q;
    cmp_d        = cmp_q;
    irq_en_d     = irq_en_q;
    match_flag_d = match_flag_q;

    if (wr) begin
      case (idx)
        IDX_GPIO_OUT: gpio_out_d = bus.datain[GPIO_W-1:0];
        IDX_CTRL: begin
          en_d      = bus.datain[CTRL_EN_BIT];
          autoclr_d = bus.datain[CTRL_AUTOCLR_BIT];
          pre_d     = bus.datain[CTRL_PRE_MSB:CTRL_PRE_LSB];
        end
        IDX_CMP:    cmp_d    = bus.datain;
        IDX_STATUS: irq_en_d = bus.datain[STATUS_IRQEN_BIT];
        default: ;
      endcase
    end

    // Clear first, then set, so a match on the same edge as W1C wins.
    if (wr && (idx == IDX_STATUS) && bus.datain[STATUS_MATCH_BIT]) begin
      match_flag_d = 1'b0;
    end
    if (match) begin
      match_flag_d = 1'b1;
    end
  end

  // Zero-latency read mux; unimplemented bits and unmapped offsets read 0.
  always_comb begin
    bus.dataout = '0;
    if (bus.hit) begin
      case (idx)
        IDX_GPIO_OUT: bus.dataout[GPIO_W-1:0] = gpio_out_q;
        IDX_GPIO_IN:  bus.dataout[GPIO_W-1:0] = sync2_q;
        IDX_CTRL: begin
          bus.dataout[CTRL_EN_BIT]                = en_q;
          bus.dataout[CTRL_AUTOCLR_BIT]           = autoclr_q;
          bus.dataout[CTRL_PRE_MSB:CTRL_PRE_LSB]  = pre_q;
        end
        IDX_COUNT:  bus.dataout = count;
        IDX_CMP:    bus.dataout = cmp_q;
        IDX_STATUS: begin
          bus.dataout[STATUS_MATCH_BIT] = match_flag_q;
          bus.dataout[STATUS_IRQEN_BIT] = irq_en_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      gpio_out_q   <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      en_q         <= 1'b0;
      autoclr_q    <= 1'b0;
      pre_q        <= '0;
      cmp_q        <= CMP_RESET;
      match_flag_q <= 1'b0;
      irq_en_q     <= 1'b0;
    end else begin
      gpio_out_q   <= gpio_out_d;
      sync1_q      <= gpio_in;
      sync2_q      <= sync1_q;
      en_q         <= en_d;
      autoclr_q    <= autoclr_d;
      pre_q        <= pre_d;
      cmp_q        <= cmp_d;
      match_flag_q <= match_flag_d;
      irq_en_q     <= irq_en_d;
    end
  end

endmodule

// File: tb/tb_pl_mmio_timer.sv
// Self-checking bench for pl_mmio_timer: a register-level model updated on
// each clock edge is compared against hit/dataout/irq/gpio_out on every
// falling edge, and directed sequences pin key values with literals.
module tb_pl_mmio_timer;

  localparam int          GW   = 8;
  localparam logic [31:0] BASE = 32'h00FF_FF00;

  logic          clk = 1'b0;
  logic          clrn;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic          irq;

  int n_compared = 0;
  int n_mismatch = 0;

  pl_mmio_timer_if bus ();

  pl_mmio_timer #(.IO_BASE(24'h00FFFF), .GPIO_W(GW)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .bus      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [GW-1:0] m_gpio_out;
  logic [GW-1:0] m_pin_hist [2];   // [0]: pins at last edge, [1]: edge before
  logic          m_en, m_autoclr, m_flag, m_irqen;
  logic [7:0]    m_pre;
  int            m_phase;          // cycles since last tick / prescaler restart
  logic [31:0]   m_count, m_cmp;

  logic       m_wr, m_tick, m_restart;
  logic [7:0] m_off;

  assign m_off     = bus.addr[7:0] & 8'hFC;
  assign m_wr      = bus.we && (bus.addr[31:8] == 24'h00FFFF);
  assign m_tick    = m_en && (m_phase == int'(m_pre));
  assign m_restart = m_wr && (m_off == 8'h08) && (bus.datain[15:8] != m_pre);

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_gpio_out    <= '0;
      m_pin_hist[0] <= '0;
      m_pin_hist[1] <= '0;
      m_en          <= 1'b0;
      m_autoclr     <= 1'b0;
      m_pre         <= '0;
      m_phase       <= 0;
      m_count       <= '0;
      m_cmp         <= 32'hFFFF_FFFF;
      m_flag        <= 1'b0;
      m_irqen       <= 1'b0;
    end else begin
      m_pin_hist[0] <= gpio_in;
      m_pin_hist[1] <= m_pin_hist[0];
      m_phase       <= (!m_en || m_restart || m_tick) ? 0 : m_phase + 1;
      if (m_wr && m_off == 8'h00) m_gpio_out <= bus.datain[GW-1:0];
      if (m_wr && m_off == 8'h08) begin
        m_en      <= bus.datain[0];
        m_autoclr <= bus.datain[1];
        m_pre     <= bus.datain[15:8];
      end
      if (m_wr && m_off == 8'h0C)  m_count <= bus.datain;
      else if (m_tick)             m_count <= (m_count == m_cmp && m_autoclr) ? 32'd0 : m_count + 32'd1;
      if (m_wr && m_off == 8'h10)  m_cmp   <= bus.datain;
      if (m_wr && m_off == 8'h14)  m_irqen <= bus.datain[1];
      if (m_tick && m_count == m_cmp)                        m_flag <= 1'b1;
      else if (m_wr && m_off == 8'h14 && bus.datain[0])      m_flag <= 1'b0;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:8] == 24'h00FFFF) begin
      case (a[7:0] & 8'hFC)
        8'h00:   r = {24'h0, m_gpio_out};
        8'h04:   r = {24'h0, m_pin_hist[1]};
        8'h08:   r = {16'h0, m_pre, 6'h0, m_autoclr, m_en};
        8'h0C:   r = m_count;
        8'h10:   r = m_cmp;
        8'h14:   r = {30'h0, m_irqen, m_flag};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("hit", {31'h0, bus.hit}, {31'h0, bus.addr[31:8] == 24'h00FFFF});
    check("dataout", bus.dataout, model_read(bus.addr));
    check("irq", {31'h0, irq}, {31'h0, m_flag && m_irqen});
    check("gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio_out});
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.we     = 1'b1;
    bus.addr   = a;
    bus.datain = d;
    @(posedge clk);
    #1;
    bus.we     = 1'b0;
    bus.addr   = 32'h0;
    bus.datain = 32'h0;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.dataout, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_map(input string tag);
    peek({tag, ".gpio_out_reg"}, BASE + 32'h00, 32'h0);
    peek({tag, ".gpio_in_reg"},  BASE + 32'h04, 32'h0);
    peek({tag, ".ctrl"},         BASE + 32'h08, 32'h0);
    peek({tag, ".count"},        BASE + 32'h0C, 32'h0);
    peek({tag, ".cmp"},          BASE + 32'h10, 32'hFFFF_FFFF);
    peek({tag, ".status"},       BASE + 32'h14, 32'h0);
    check({tag, ".irq"},      {31'h0, irq}, 32'h0);
    check({tag, ".gpio_pin"}, {24'h0, gpio_out}, 32'h0);
  endtask

  initial begin
    clrn       = 1'b1;
    bus.we     = 1'b0;
    bus.addr   = 32'h0;
    bus.datain = 32'h0;
    gpio_in    = '0;
    #2 clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    step(1);

    // Power-on reset values
    check_reset_map("por");
    step(1);

    // GPIO round trip
    bus_write(BASE + 32'h00, 32'h0000_00A5);
    check("gpio_out_after_wr", {24'h0, gpio_out}, 32'hA5);
    gpio_in = 8'h3C;
    peek("gpio_in_edge0", BASE + 32'h04, 32'h0);
    step(1);
    peek("gpio_in_edge1", BASE + 32'h04, 32'h0);
    step(1);
    peek("gpio_in_edge2", BASE + 32'h04, 32'h3C);

    // Prescale and wrap
    bus_write(BASE + 32'h0C, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h10, 32'h0000_0010);
    bus_write(BASE + 32'h08, 32'h0000_0301);
    peek("wrap_e0", BASE + 32'h0C, 32'hFFFF_FFFE);
    step(3);
    peek("wrap_e3", BASE + 32'h0C, 32'hFFFF_FFFE);
    step(1);
    peek("wrap_e4", BASE + 32'h0C, 32'hFFFF_FFFF);
    step(3);
    peek("wrap_e7", BASE + 32'h0C, 32'hFFFF_FFFF);
    step(1);
    peek("wrap_e8", BASE + 32'h0C, 32'h0);
    peek("wrap_status", BASE + 32'h14, 32'h0);
    bus_write(BASE + 32'h08, 32'h0);

    // Match with autoclr, irq, W1C
    bus_write(BASE + 32'h0C, 32'd3);
    bus_write(BASE + 32'h10, 32'd5);
    bus_write(BASE + 32'h14, 32'h2);
    bus_write(BASE + 32'h08, 32'h0000_0003);
    peek("match_c3", BASE + 32'h0C, 32'd3);
    step(1);
    peek("match_c4", BASE + 32'h0C, 32'd4);
    step(1);
    peek("match_c5", BASE + 32'h0C, 32'd5);
    check("irq_before_match", {31'h0, irq}, 32'h0);
    step(1);
    peek("match_autoclr", BASE + 32'h0C, 32'd0);
    check("irq_after_match", {31'h0, irq}, 32'h1);
    peek("status_match", BASE + 32'h14, 32'h3);
    bus_write(BASE + 32'h14, 32'h3);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    peek("count_after_w1c", BASE + 32'h0C, 32'd1);

    // W1C on the same edge as a match: set wins
    step(4);
    peek("count_pre_collide", BASE + 32'h0C, 32'd5);
    bus_write(BASE + 32'h14, 32'h3);
    check("irq_collide", {31'h0, irq}, 32'h1);
    peek("status_collide", BASE + 32'h14, 32'h3);
    peek("count_collide", BASE + 32'h0C, 32'd0);

    // COUNT write on a tick edge (pre=0 ticks every edge)
    bus_write(BASE + 32'h0C, 32'h100);
    peek("count_load_wins", BASE + 32'h0C, 32'h100);
    step(1);
    peek("count_after_load", BASE + 32'h0C, 32'h101);
    bus_write(BASE + 32'h08, 32'h0);
    peek("count_stopped", BASE + 32'h0C, 32'h102);
    step(2);
    peek("count_held", BASE + 32'h0C, 32'h102);

    // Out-of-window access
    bus.we     = 1'b1;
    bus.addr   = 32'h00FF_FE14;
    bus.datain = 32'h1;
    #1;
    check("oow_hit", {31'h0, bus.hit}, 32'h0);
    check("oow_dataout", bus.dataout, 32'h0);
    step(1);
    bus.we = 1'b0;
    bus_write(32'h00FF_FE00, 32'hFF);
    check("oow_gpio_kept", {24'h0, gpio_out}, 32'hA5);
    peek("oow_status_kept", BASE + 32'h14, 32'h3);

    // Unmapped offset inside the window
    bus_write(BASE + 32'h3C, 32'hFFFF_FFFF);
    peek("unmapped_read", BASE + 32'h3C, 32'h0);
    check("unmapped_hit", {31'h0, bus.hit}, 32'h1);
    peek("unmapped_gpio", BASE + 32'h00, 32'hA5);
    peek("unmapped_cmp", BASE + 32'h10, 32'd5);

    // Changing pre restarts the prescaler
    bus_write(BASE + 32'h0C, 32'h0);
    bus_write(BASE + 32'h08, 32'h0000_0301);
    step(2);
    bus_write(BASE + 32'h08, 32'h0000_0201);
    peek("pre_chg_c0", BASE + 32'h0C, 32'd0);
    step(2);
    peek("pre_chg_c0b", BASE + 32'h0C, 32'd0);
    step(1);
    peek("pre_chg_tick", BASE + 32'h0C, 32'd1);

    // Reset mid-count, then counting stays stopped
    gpio_in = '0;
    step(3);
    clrn = 1'b0;
    check_reset_map("rst_mid");
    step(2);
    clrn = 1'b1;
    step(5);
    check_reset_map("post_rst");

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
